// File: rtl/mat_addr_gen.sv
// Address sequencer for D[i][j] = sum_k A[i][k]*B[k][j]: walks i/j/k and emits
// one (A, B, D) address triple per beat with accumulator first/last flags.
module mat_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int DIM_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_i,
  input  logic [DIM_W-1:0]  dim_j,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_d,
  input  logic              ready,
  output logic              valid,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_d,
  output logic              first_k,
  output logic              last_k,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat transfers on any rising edge where valid && ready.
  // valid is high for the whole RUN state and never drops without a transfer;
  // all beat outputs hold while valid && !ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DIM_W-1:0]  DIM_ZERO  = '0;
  localparam logic [DIM_W-1:0]  DIM_ONE   = DIM_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  dim_i_q, dim_i_d;
  logic [DIM_W-1:0]  dim_j_q, dim_j_d;
  logic [DIM_W-1:0]  dim_k_q, dim_k_d;
  logic [ADDR_W-1:0] base_b_q, base_b_d;
  logic [DIM_W-1:0]  i_q, i_d;
  logic [DIM_W-1:0]  j_q, j_d;
  logic [DIM_W-1:0]  k_q, k_d;
  logic [ADDR_W-1:0] row_a_q, row_a_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [ADDR_W-1:0] addr_d_q, addr_d_d;
  logic              first_k_q, first_k_d;
  logic              last_k_q, last_k_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DIM_W-1:0]  i_last, j_last, k_last;
  logic [ADDR_W-1:0] stride_j, stride_k;

  always_comb begin
    i_last   = dim_i_q - DIM_ONE;
    j_last   = dim_j_q - DIM_ONE;
    k_last   = dim_k_q - DIM_ONE;
    stride_j = ADDR_W'(dim_j_q);
    stride_k = ADDR_W'(dim_k_q);

    state_d   = state_q;
    dim_i_d   = dim_i_q;
    dim_j_d   = dim_j_q;
    dim_k_d   = dim_k_q;
    base_b_d  = base_b_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    row_a_d   = row_a_q;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    addr_d_d  = addr_d_q;
    first_k_d = first_k_q;
    last_k_d  = last_k_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dim_i_d   = dim_i;
          dim_j_d   = dim_j;
          dim_k_d   = dim_k;
          base_b_d  = base_b;
          i_d       = DIM_ZERO;
          j_d       = DIM_ZERO;
          k_d       = DIM_ZERO;
          row_a_d   = base_a;
          addr_a_d  = base_a;
          addr_b_d  = base_b;
          addr_d_d  = base_d;
          first_k_d = 1'b1;
          last_k_d  = (dim_k == DIM_ONE);
          if (dim_i == DIM_ZERO || dim_j == DIM_ZERO || dim_k == DIM_ZERO) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (ready) begin
          if (k_q != k_last) begin
            k_d      = k_q + DIM_ONE;
            addr_a_d = addr_a_q + ADDR_ONE;
            addr_b_d = addr_b_q + stride_j;
          end else if (j_q != j_last) begin
            // Column step: A rewinds to the row start, B moves to the next column.
            k_d      = DIM_ZERO;
            j_d      = j_q + DIM_ONE;
            addr_a_d = row_a_q;
            addr_b_d = base_b_q + ADDR_W'(j_q) + ADDR_ONE;
            addr_d_d = addr_d_q + ADDR_ONE;
          end else if (i_q != i_last) begin
            k_d      = DIM_ZERO;
            j_d      = DIM_ZERO;
            i_d      = i_q + DIM_ONE;
            row_a_d  = row_a_q + stride_k;
            addr_a_d = row_a_q + stride_k;
            addr_b_d = base_b_q;
            addr_d_d = addr_d_q + ADDR_ONE;
          end else begin
            state_d = S_DONE;
          end
          first_k_d = (k_d == DIM_ZERO);
          last_k_d  = (k_d == k_last);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flags only carry meaning alongside valid; park them low otherwise.
    if (state_d != S_RUN) begin
      first_k_d = 1'b0;
      last_k_d  = 1'b0;
    end

    valid_d = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dim_i_q   <= '0;
      dim_j_q   <= '0;
      dim_k_q   <= '0;
      base_b_q  <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      row_a_q   <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      addr_d_q  <= '0;
      first_k_q <= 1'b0;
      last_k_q  <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dim_i_q   <= dim_i_d;
      dim_j_q   <= dim_j_d;
      dim_k_q   <= dim_k_d;
      base_b_q  <= base_b_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      row_a_q   <= row_a_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      addr_d_q  <= addr_d_d;
      first_k_q <= first_k_d;
      last_k_q  <= last_k_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign valid     = valid_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign addr_d    = addr_d_q;
  assign first_k   = first_k_q;
  assign last_k    = last_k_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mat_addr_gen.sv
// Directed bench for mat_addr_gen: each scenario task drives its stimulus and
// compares beats against hand-computed addresses at the falling clock edge.
module tb_mat_addr_gen;

  localparam int ADDR_W = 8;
  localparam int DIM_W  = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [DIM_W-1:0]  dim_i, dim_j, dim_k;
  logic [ADDR_W-1:0] base_a, base_b, base_d;
  logic              ready;
  logic              valid;
  logic [ADDR_W-1:0] addr_a, addr_b, addr_d;
  logic              first_k, last_k, busy, done;
  logic [1:0]        dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Expected 2x2x2 beat sequence with bases 00/10/20.
  logic [7:0] basic_a[8] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h02, 8'h03};
  logic [7:0] basic_b[8] = '{8'h10, 8'h12, 8'h11, 8'h13, 8'h10, 8'h12, 8'h11, 8'h13};
  logic [7:0] basic_d[8] = '{8'h20, 8'h20, 8'h21, 8'h21, 8'h22, 8'h22, 8'h23, 8'h23};

  mat_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .dim_i(dim_i), .dim_j(dim_j), .dim_k(dim_k),
    .base_a(base_a), .base_b(base_b), .base_d(base_d),
    .ready(ready), .valid(valid),
    .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d),
    .first_k(first_k), .last_k(last_k), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // Called on a falling edge; returns on the falling edge after start was sampled.
  task automatic do_start(input logic [DIM_W-1:0] ni, nj, nk,
                          input logic [ADDR_W-1:0] ba, bb, bd);
    dim_i = ni; dim_j = nj; dim_k = nk;
    base_a = ba; base_b = bb; base_d = bd;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset;
    logic [33:0] got;
    reset = 1'b1; start = 1'b0; ready = 1'b0;
    dim_i = '0; dim_j = '0; dim_k = '0;
    base_a = '0; base_b = '0; base_d = '0;
    #1;
    got = {valid, busy, done, first_k, last_k, addr_a, addr_b, addr_d, dbg_state, 3'b000};
    vec_cnt++;
    if (got !== 34'h0) begin
      $display("FAIL reset_outputs: got %h expected 0", got);
      err_cnt++;
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    vec_cnt++;
    if ({valid, busy, done, dbg_state} !== 5'b0) begin
      $display("FAIL reset_idle: got %b expected 00000", {valid, busy, done, dbg_state});
      err_cnt++;
    end
  endtask

  task automatic test_basic;
    logic [26:0] got, want;
    ready = 1'b1;
    do_start(8'd2, 8'd2, 8'd2, 8'h00, 8'h10, 8'h20);
    for (int b = 0; b < 8; b++) begin
      got  = {valid, addr_a, addr_b, addr_d, first_k, last_k};
      want = {1'b1, basic_a[b], basic_b[b], basic_d[b], (b % 2 == 0), (b % 2 == 1)};
      vec_cnt++;
      if (got !== want) begin
        $display("FAIL basic_beat%0d: got %h expected %h", b, got, want);
        err_cnt++;
      end
      @(negedge clock);
    end
    vec_cnt++;
    if ({valid, done, busy} !== 3'b011) begin
      $display("FAIL basic_done: got %b expected 011", {valid, done, busy});
      err_cnt++;
    end
    @(negedge clock);
    vec_cnt++;
    if ({valid, done, busy, dbg_state} !== 5'b00000) begin
      $display("FAIL basic_idle: got %b expected 00000", {valid, done, busy, dbg_state});
      err_cnt++;
    end
  endtask

  task automatic test_backpressure;
    logic [26:0] got, want;
    int b = 0;
    int c = 0;
    ready = 1'b1;
    do_start(8'd2, 8'd2, 8'd2, 8'h00, 8'h10, 8'h20);
    while (b < 8 && c < 64) begin
      got  = {valid, addr_a, addr_b, addr_d, first_k, last_k};
      want = {1'b1, basic_a[b], basic_b[b], basic_d[b], (b % 2 == 0), (b % 2 == 1)};
      vec_cnt++;
      if (got !== want) begin
        $display("FAIL bp_cycle%0d_beat%0d: got %h expected %h", c, b, got, want);
        err_cnt++;
      end
      ready = (c % 4 == 0) || (c % 4 == 3);
      @(negedge clock);
      if (ready) b++;
      c++;
    end
    ready = 1'b1;
    vec_cnt++;
    if (b != 8) begin
      $display("FAIL bp_accept_count: got %0d expected 8 (cycle budget expired)", b);
      err_cnt++;
    end
    vec_cnt++;
    if ({valid, done, busy} !== 3'b011) begin
      $display("FAIL bp_done: got %b expected 011", {valid, done, busy});
      err_cnt++;
    end
    @(negedge clock);
  endtask

  task automatic test_zero_dim;
    ready = 1'b1;
    do_start(8'd3, 8'd0, 8'd2, 8'h00, 8'h10, 8'h20);
    vec_cnt++;
    if ({valid, done, busy} !== 3'b011) begin
      $display("FAIL zero_done: got %b expected 011", {valid, done, busy});
      err_cnt++;
    end
    @(negedge clock);
    vec_cnt++;
    if ({valid, done, busy, dbg_state} !== 5'b00000) begin
      $display("FAIL zero_idle: got %b expected 00000", {valid, done, busy, dbg_state});
      err_cnt++;
    end
  endtask

  task automatic test_wrap;
    logic [7:0]  wa[3] = '{8'hFE, 8'hFF, 8'h00};
    logic [7:0]  wb[3] = '{8'hFF, 8'h00, 8'h01};
    logic [26:0] got, want;
    ready = 1'b1;
    do_start(8'd1, 8'd1, 8'd3, 8'hFE, 8'hFF, 8'h30);
    for (int k = 0; k < 3; k++) begin
      got  = {valid, addr_a, addr_b, addr_d, first_k, last_k};
      want = {1'b1, wa[k], wb[k], 8'h30, (k == 0), (k == 2)};
      vec_cnt++;
      if (got !== want) begin
        $display("FAIL wrap_beat%0d: got %h expected %h", k, got, want);
        err_cnt++;
      end
      @(negedge clock);
    end
    vec_cnt++;
    if ({valid, done} !== 2'b01) begin
      $display("FAIL wrap_done: got %b expected 01", {valid, done});
      err_cnt++;
    end
    @(negedge clock);
  endtask

  task automatic test_k1;
    logic [26:0] got, want;
    logic [7:0]  ea, eb, ed;
    ready = 1'b1;
    do_start(8'd2, 8'd3, 8'd1, 8'h00, 8'h80, 8'h40);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 3; j++) begin
        ea   = 8'(i);
        eb   = 8'(8'h80 + j);
        ed   = 8'(8'h40 + i * 3 + j);
        got  = {valid, addr_a, addr_b, addr_d, first_k, last_k};
        want = {1'b1, ea, eb, ed, 1'b1, 1'b1};
        vec_cnt++;
        if (got !== want) begin
          $display("FAIL k1_beat_i%0d_j%0d: got %h expected %h", i, j, got, want);
          err_cnt++;
        end
        @(negedge clock);
      end
    end
    vec_cnt++;
    if ({valid, done} !== 2'b01) begin
      $display("FAIL k1_done: got %b expected 01", {valid, done});
      err_cnt++;
    end
    @(negedge clock);
  endtask

  task automatic test_reset_midrun;
    logic [26:0] got, want;
    logic [33:0] all;
    ready = 1'b1;
    do_start(8'd2, 8'd2, 8'd2, 8'h00, 8'h10, 8'h20);
    for (int b = 0; b < 5; b++) begin
      got  = {valid, addr_a, addr_b, addr_d, first_k, last_k};
      want = {1'b1, basic_a[b], basic_b[b], basic_d[b], (b % 2 == 0), (b % 2 == 1)};
      vec_cnt++;
      if (got !== want) begin
        $display("FAIL ignstart_beat%0d: got %h expected %h", b, got, want);
        err_cnt++;
      end
      if (b == 2) begin
        start = 1'b1; dim_i = 8'd5; dim_k = 8'd1; base_a = 8'h77; base_b = 8'h55;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    all = {valid, busy, done, first_k, last_k, addr_a, addr_b, addr_d, dbg_state, 3'b000};
    vec_cnt++;
    if (all !== 34'h0) begin
      $display("FAIL async_reset: got %h expected 0", all);
      err_cnt++;
    end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vec_cnt++;
      if ({done, busy, valid} !== 3'b000) begin
        $display("FAIL reset_no_done%0d: got %b expected 000", c, {done, busy, valid});
        err_cnt++;
      end
      @(negedge clock);
    end
    do_start(8'd2, 8'd2, 8'd2, 8'h00, 8'h10, 8'h20);
    for (int b = 0; b < 8; b++) begin
      got  = {valid, addr_a, addr_b, addr_d, first_k, last_k};
      want = {1'b1, basic_a[b], basic_b[b], basic_d[b], (b % 2 == 0), (b % 2 == 1)};
      vec_cnt++;
      if (got !== want) begin
        $display("FAIL rerun_beat%0d: got %h expected %h", b, got, want);
        err_cnt++;
      end
      @(negedge clock);
    end
    vec_cnt++;
    if ({valid, done, busy} !== 3'b011) begin
      $display("FAIL rerun_done: got %b expected 011", {valid, done, busy});
      err_cnt++;
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_dim();
    test_wrap();
    test_k1();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
